bit_serializer: RTL
===================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the bits per input word.
REQ-002 SHALL have parameter DEPTH, default 4, giving the input FIFO entries; DEPTH is a power of 2 and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port data_in, input, WIDTH bits: parallel word from the producer.
REQ-006 SHALL have port data_valid, input, 1 bit: data_in is valid this cycle.
REQ-007 SHALL have port data_ready, output, 1 bit: the block accepts a word this cycle.
REQ-008 SHALL have port ser_en, input, 1 bit: when 0, the serial stream pauses.
REQ-009 SHALL have port ser_out, output, 1 bit: serial bit feeding the pattern detector's in.
REQ-010 SHALL have port ser_valid, output, 1 bit: ser_out is valid; feeds the detector's valid.
REQ-011 SHALL have port word_cnt, output, 16 bits: count of fully emitted words.

Function
REQ-012 SHALL accept a word on every rising edge where data_valid and data_ready are both 1.
REQ-013 SHALL drive data_ready = !fifo_full, where fifo_full is registered; a push is never attempted when full, including in a pop cycle.
REQ-014 SHALL implement an FSM with states S_IDLE and S_SHIFT.
REQ-015 In S_IDLE, when the FIFO is non-empty and ser_en=1: SHALL pop a word into the shift register, set bit_cnt=WIDTH-1, and go to S_SHIFT.
REQ-016 In S_SHIFT, when ser_en=1: SHALL register ser_out from the current bit, register ser_valid=1, and decrement bit_cnt.
REQ-017 In S_SHIFT, when ser_en=0: SHALL register ser_valid=0, hold ser_out, hold bit_cnt and the shift register, and emit no bit.
REQ-018 On the last bit (bit_cnt=0, ser_en=1): SHALL pop the next word in the same cycle if the FIFO is non-empty, so there is no gap between words; otherwise SHALL return to S_IDLE.
REQ-019 Latency: a word pushed at edge k with the FSM in S_IDLE SHALL produce its first ser_valid=1 bit in the cycle after edge k+2, then one bit per enabled cycle.
REQ-020 SHALL have no FIFO bypass; a push into an empty FIFO is visible to the FSM one edge later.
REQ-021 SHALL increment word_cnt at the edge that emits the last bit of a word; 0xFFFF wraps to 0x0000.
REQ-022 In S_IDLE, or when ser_en=0, SHALL hold ser_valid at 0.

Reset
REQ-023 While rst=1 at an edge: FIFO pointers and count SHALL clear to 0, FSM SHALL go to S_IDLE, and ser_out, ser_valid and word_cnt SHALL clear to 0.
REQ-024 SHALL drive data_ready=0 while rst=1 and data_ready=1 from the first edge after rst falls.
REQ-025 A mid-word reset SHALL discard the in-flight word and all FIFO contents; no partial bits are emitted afterwards.

Configuration
REQ-026 With macro SER_LSB_FIRST_EN defined, SHALL emit bit 0 first and bit WIDTH-1 last.
REQ-027 Without SER_LSB_FIRST_EN, SHALL emit bit WIDTH-1 first (MSB-first); this is the default.

Structure
REQ-028 Package ser_pkg SHALL hold the FSM state typedef (S_IDLE, S_SHIFT), WIDTH_DEF=8, DEPTH_DEF=4 and the word_cnt width of 16.
REQ-029 The FIFO SHALL be a sub-module ser_fifo (sync, registered full/empty, push/pop/count); the FSM and shift register stay in bit_serializer.

Verification
REQ-030 Reset, then push 0x66 MSB-first with ser_en=1 -> ser_out 0,1,1,0,0,1,1,0 on 8 consecutive ser_valid cycles; word_cnt=1; the downstream non-overlap 0110 detector fires twice.
REQ-031 Push 0xA5 then 0x3C back-to-back -> 16 contiguous ser_valid cycles with no gap; word_cnt=2.
REQ-032 Push 5 words with ser_en=0 (DEPTH=4) -> data_ready=0 after 4 pushes; release ser_en -> all 4 words are emitted in order and data_ready returns to 1.
REQ-033 ser_en toggles 1,0,1 during word 0xF0 -> ser_valid=0 in the paused cycle, no bit lost or duplicated, output stream 11110000.
REQ-034 Assert rst for 1 cycle after the 3rd bit of 0xFF -> ser_valid=0, word_cnt=0, FIFO empty; a next push of 0x0F streams cleanly.
REQ-035 Build with SER_LSB_FIRST_EN and push 0x01 -> ser_out 1,0,0,0,0,0,0,0.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared types and defaults for the bit serializer slice.
// Optional feature macro: SER_LSB_FIRST_EN (LSB-first emission).
package ser_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;
  localparam int WCNT_W    = 16;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ser_fifo.sv
// Synchronous word FIFO with registered full/empty flags and occupancy count.
// Show-ahead read: o_rdata always presents the head entry.
module ser_fifo
  import ser_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = cnt_w(DEPTH);
  localparam int CW = cnt_w(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_count_nxt;

  assign w_push  = i_push && !r_full;
  assign w_pop   = i_pop && !r_empty;
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Flags are derived from the next count so they are registered yet exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: FIFO-buffered words shifted out one bit per enabled cycle.
// Define SER_LSB_FIRST_EN for bit-0-first emission; default is MSB-first.
module bit_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              ser_en,
  output logic              ser_out,
  output logic              ser_valid,
  output logic [WCNT_W-1:0] word_cnt
);

  localparam int BW = cnt_w(WIDTH);

  ser_state_t        r_state;
  logic [WIDTH-1:0]  r_shift;
  logic [BW-1:0]     r_bit_cnt;
  logic              r_ser_out;
  logic              r_ser_valid;
  logic [WCNT_W-1:0] r_word_cnt;

  logic              w_full;
  logic              w_empty;
  logic [WIDTH-1:0]  w_fifo_data;
  logic              w_push;
  logic              w_pop;
  logic              w_last;
  logic              w_cur_bit;
  logic [WIDTH-1:0]  w_shift_nxt;

  assign data_ready = !w_full && !rst;
  assign w_push     = data_valid && data_ready;
  assign w_last     = (r_bit_cnt == '0);

`ifdef SER_LSB_FIRST_EN
  assign w_cur_bit   = r_shift[0];
  assign w_shift_nxt = {1'b0, r_shift[WIDTH-1:1]};
`else
  assign w_cur_bit   = r_shift[WIDTH-1];
  assign w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
`endif

  // A pop in S_SHIFT only happens alongside the last bit, keeping words gap-free.
  always_comb begin
    w_pop = 1'b0;
    if (ser_en && !w_empty) begin
      unique case (r_state)
        S_IDLE:  w_pop = 1'b1;
        S_SHIFT: w_pop = w_last;
        default: w_pop = 1'b0;
      endcase
    end
  end

  ser_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (data_in),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_word_cnt  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_ser_valid <= 1'b0;
          if (w_pop) begin
            r_shift   <= w_fifo_data;
            r_bit_cnt <= BW'(WIDTH - 1);
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (ser_en) begin
            r_ser_out   <= w_cur_bit;
            r_ser_valid <= 1'b1;
            if (w_last) begin
              r_word_cnt <= r_word_cnt + 1'b1;
              if (w_pop) begin
                r_shift   <= w_fifo_data;
                r_bit_cnt <= BW'(WIDTH - 1);
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_shift   <= w_shift_nxt;
              r_bit_cnt <= r_bit_cnt - 1'b1;
            end
          end else begin
            r_ser_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ser_out   = r_ser_out;
  assign ser_valid = r_ser_valid;
  assign word_cnt  = r_word_cnt;

endmodule
